// File: rtl/matmul_load_sequencer.sv
// rtl/matmul_load_sequencer.sv - operand load / multiply sequencer for the matmul datapath
// Optional watchdog: define MMC_TIMEOUT_EN to enable the LOAD/WAIT timeout and the err flag.
module matmul_load_sequencer #(
  parameter int N_BITS      = 8,
  parameter int MAT_ELEMS   = 16,
  parameter int NUM_PAIRS   = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  output logic                         gen_req,
  input  logic [N_BITS-1:0]            gen_data,
  input  logic                         gen_valid,
  output logic                         buf_we,
  output logic                         buf_sel,
  output logic [$clog2(MAT_ELEMS)-1:0] buf_addr,
  output logic [N_BITS-1:0]            buf_wdata,
  output logic                         mul_start,
  input  logic                         mul_done,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   pair_idx,
  output logic                         err
);

  localparam int AW = $clog2(MAT_ELEMS);
  localparam int TW = $clog2(TIMEOUT_CYC);

`ifdef MMC_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, REQ_A, LOAD_A, REQ_B, LOAD_B, KICK, WAIT_MUL, FINISH
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   elem_cnt;
  logic [TW-1:0]   wd_cnt;
  logic            loading;
  logic            beat;
  logic            last_beat;
  logic            last_pair;
  logic            wd_active;
  logic            wd_kick;
  logic            timeout;

  assign loading   = (state == LOAD_A) || (state == LOAD_B);
  // A beat that arrives together with abort is dropped; only the already registered write lands.
  assign beat      = loading && gen_valid && !abort;
  assign last_beat = beat && (elem_cnt == AW'(MAT_ELEMS - 1));
  assign last_pair = (pair_idx == 2'(NUM_PAIRS - 1));

  assign wd_active = loading || (state == WAIT_MUL);
  assign wd_kick   = (loading && gen_valid) || ((state == WAIT_MUL) && mul_done);
  assign timeout   = WD_EN && wd_active && !wd_kick && (wd_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort || timeout) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (start) state_nxt = REQ_A;
        REQ_A:    state_nxt = LOAD_A;
        LOAD_A:   if (last_beat) state_nxt = REQ_B;
        REQ_B:    state_nxt = LOAD_B;
        LOAD_B:   if (last_beat) state_nxt = KICK;
        KICK:     state_nxt = WAIT_MUL;
        WAIT_MUL: if (mul_done) state_nxt = last_pair ? FINISH : REQ_A;
        FINISH:   state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    gen_req   = (state == REQ_A) || (state == REQ_B);
    mul_start = (state == KICK) && !abort;
    done      = (state == FINISH) && !abort;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_we    <= 1'b0;
      buf_sel   <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      elem_cnt  <= '0;
    end else begin
      buf_we <= beat;
      if (beat) begin
        buf_sel   <= (state == LOAD_B);
        buf_addr  <= elem_cnt;
        buf_wdata <= gen_data;
      end
      if (gen_req) elem_cnt <= '0;
      else if (beat) elem_cnt <= last_beat ? '0 : elem_cnt + 1'b1;
    end
  end

  // pair_idx keeps its final value after FINISH or abort until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_idx <= '0;
    end else if (!abort) begin
      if ((state == IDLE) && start)                    pair_idx <= '0;
      else if ((state == WAIT_MUL) && mul_done && !last_pair) pair_idx <= pair_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (!WD_EN || !wd_active || wd_kick || (state_nxt != state)) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (!abort) begin
      if ((state == IDLE) && start) err <= 1'b0;
      else if (timeout)             err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_matmul_load_sequencer.sv
// tb/tb_matmul_load_sequencer.sv - self-checking bench for matmul_load_sequencer
// Generator, multiplier and expected sequence are modelled in terms of bursts and write indices.
module tb_matmul_load_sequencer;
  localparam int NUM_PAIRS   = 3;
  localparam int TIMEOUT_CYC = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       gen_req;
  logic [7:0] gen_data = 8'h00;
  logic       gen_valid = 1'b0;
  logic       buf_we;
  logic       buf_sel;
  logic [3:0] buf_addr;
  logic [7:0] buf_wdata;
  logic       mul_start;
  logic       mul_done = 1'b0;
  logic       busy;
  logic       done;
  logic [1:0] pair_idx;
  logic       err;

  matmul_load_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .gen_req(gen_req), .gen_data(gen_data), .gen_valid(gen_valid),
    .buf_we(buf_we), .buf_sel(buf_sel), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .mul_start(mul_start), .mul_done(mul_done), .busy(busy), .done(done),
    .pair_idx(pair_idx), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus knobs
  int gap_mode = 0;
  int mul_delay = 5;
  bit rand_mul = 0;
  bit seq_data = 1;
  int seq_val = 0;
  bit drv_start_once = 0;
  bit pulse_start_busy = 0;
  bit spurious_en = 0;
  int abort_at_beat = -1;
  bit stall_en = 0;
  int stall_after = 0;
  int stall_left = 0;
  int cyc_cnt = 0;

  // reference model
  bit m_busy = 0, m_wait = 0, m_err = 0;
  bit we_pend = 0, req_pend = 0, done_pend = 0;
  int m_pair = 0, m_k = 0, beats = 0, burst_left = 0, mul_cnt = 0, tcnt = 0;
  logic [7:0] dq[$];
  int n_req = 0, n_mul = 0, n_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_err = 0; we_pend = 0; req_pend = 0; done_pend = 0;
    m_pair = 0; m_k = 0; beats = 0; burst_left = 0; mul_cnt = 0; tcnt = 0;
    dq.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".gen_req"}, gen_req, 0);
    chk({tag, ".buf_we"}, buf_we, 0);
    chk({tag, ".buf_sel"}, buf_sel, 0);
    chk({tag, ".buf_addr"}, buf_addr, 0);
    chk({tag, ".buf_wdata"}, buf_wdata, 0);
    chk({tag, ".mul_start"}, mul_start, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pair_idx"}, pair_idx, 0);
    chk({tag, ".err"}, err, 0);
  endtask

  task automatic cycle();
    bit beat, loading, acc, was_busy, last_a, last_b, exp_req, exp_ms, exp_dn;
    int k;
    @(posedge clk); #1;
    start = 0; abort = 0; mul_done = 0; gen_valid = 0; gen_data = 8'($urandom);
    cyc_cnt++;
    loading = (burst_left > 0);
    beat = 0;
    if (drv_start_once) begin start = 1; drv_start_once = 0; end
    else if (pulse_start_busy && m_busy) start = 1'($urandom_range(0, 1));
    if (loading) begin
      if (stall_en && beats >= stall_after && stall_left > 0) stall_left--;
      else if (gap_mode == 0 || (gap_mode == 1 && cyc_cnt % 2 == 0) ||
               (gap_mode == 2 && $urandom_range(0, 1) == 1)) beat = 1;
    end else if (spurious_en) gen_valid = 1'($urandom_range(0, 1));
    if (beat) begin
      gen_valid = 1;
      gen_data = seq_data ? 8'(seq_val) : 8'($urandom);
      if (seq_data) seq_val++;
    end
    if (abort_at_beat >= 0 && beat && beats == abort_at_beat) begin abort = 1; abort_at_beat = -1; end
    if (spurious_en && loading && (beats % 32) < 16 && $urandom_range(0, 3) == 0) mul_done = 1;
    if (mul_cnt > 0) begin mul_cnt--; if (mul_cnt == 0) mul_done = 1; end
    #1;
    last_a = 0; last_b = 0;
    chk("buf_we", buf_we, we_pend);
    if (we_pend) begin
      k = m_k;
      chk("buf_sel", buf_sel, (k / 16) % 2);
      chk("buf_addr", buf_addr, k % 16);
      chk("buf_wdata", buf_wdata, dq.pop_front());
      last_a = (k % 32 == 15);
      last_b = (k % 32 == 31);
      m_k++;
    end
    exp_req = req_pend || last_a;
    exp_ms = last_b && !abort;
    exp_dn = done_pend && !abort;
    chk("gen_req", gen_req, exp_req);
    chk("mul_start", mul_start, exp_ms);
    chk("done", done, exp_dn);
    chk("busy", busy, m_busy);
    chk("pair_idx", pair_idx, m_pair);
    chk("err", err, m_err);
    if (gen_req === 1'b1) n_req++;
    if (mul_start === 1'b1) n_mul++;
    if (done === 1'b1) n_done++;
    was_busy = m_busy;
    acc = beat && !abort;
    if (abort) begin
      m_busy = 0; m_wait = 0; we_pend = 0; req_pend = 0; done_pend = 0;
      burst_left = 0; mul_cnt = 0; dq.delete();
    end else begin
      we_pend = acc;
      if (acc) begin dq.push_back(gen_data); burst_left--; beats++; end
      req_pend = 0; done_pend = 0;
      if (exp_req) begin burst_left = 16; tcnt = 0; end
      if (mul_done && m_wait) begin
        m_wait = 0;
        if (m_pair == NUM_PAIRS - 1) done_pend = 1;
        else begin m_pair++; req_pend = 1; end
      end
      if (exp_ms) begin
        m_wait = 1;
        mul_cnt = rand_mul ? $urandom_range(1, 8) : mul_delay;
      end
      if (exp_dn) m_busy = 0;
      if (start && !was_busy) begin
        m_busy = 1; m_pair = 0; m_err = 0; req_pend = 1; m_k = 0; beats = 0;
      end
`ifdef MMC_TIMEOUT_EN
      if (loading) begin
        if (acc) tcnt = 0;
        else if (tcnt == TIMEOUT_CYC - 1) begin
          m_busy = 0; m_err = 1; burst_left = 0; we_pend = 0; req_pend = 0; m_wait = 0;
        end else tcnt++;
      end
`endif
    end
  endtask

  task automatic run(input int max_cyc);
    int cyc;
    cyc = 0;
    n_req = 0; n_mul = 0; n_done = 0;
    drv_start_once = 1;
    cycle();
    while (m_busy && cyc < max_cyc) begin cycle(); cyc++; end
    chk("run_bound", cyc < max_cyc, 1);
    cycle();
  endtask

  initial begin
    int cyc;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // back-to-back stream 0x00..0x5F, multiplier answers after 5 cycles
    gap_mode = 0; seq_data = 1; seq_val = 0; mul_delay = 5; rand_mul = 0;
    run(400);
    chk("t1.gen_req_count", n_req, 6);
    chk("t1.mul_start_count", n_mul, 3);
    chk("t1.done_count", n_done, 1);
    chk("t1.pair_idx_final", pair_idx, 2);

    // alternating gen_valid
    gap_mode = 1; seq_data = 0;
    run(600);
    chk("t2.mul_start_count", n_mul, 3);

    // random gaps and random multiplier latency
    gap_mode = 2; rand_mul = 1;
    run(1000);
    chk("t2r.done_count", n_done, 1);

    // abort on the 8th beat of B in pair 1, then restart
    gap_mode = 2; abort_at_beat = 32 + 16 + 7;
    run(1000);
    chk("t3.mul_start_count", n_mul, 1);
    chk("t3.done_count", n_done, 0);
    repeat (3) cycle();
    run(1000);
    chk("t3.restart_done_count", n_done, 1);

    // start pulses while busy and spurious mul_done / gen_valid outside their states
    pulse_start_busy = 1; spurious_en = 1;
    run(1000);
    chk("t4.mul_start_count", n_mul, 3);
    chk("t4.done_count", n_done, 1);
    pulse_start_busy = 0; spurious_en = 0;

    // generator stalls after 5 beats of A
    gap_mode = 0; stall_en = 1; stall_after = 5; stall_left = 80;
    run(1000);
    stall_en = 0;
`ifdef MMC_TIMEOUT_EN
    chk("t5.err_set", err, 1);
    chk("t5.done_count", n_done, 0);
    run(400);
    chk("t5.err_cleared", err, 0);
`else
    chk("t5.err_clear", err, 0);
    chk("t5.done_count", n_done, 1);
`endif

    // asynchronous reset while waiting on the multiplier
    rand_mul = 0; mul_delay = 8;
    drv_start_once = 1;
    cyc = 0;
    cycle();
    while (!m_wait && cyc < 400) begin cycle(); cyc++; end
    chk("t6.reach_wait", m_wait, 1);
    cycle();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t6.async_reset");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    run(400);
    chk("t6.after_reset_done_count", n_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
